fc_result_reader: RTL
=====================

# fc_result_reader

Consumer at the far end of the second fully connected layer. It tracks the layer's free-running 26-slot × 30-line output schedule, snapshots the ten 16-bit class scores once all ten are rewritten, and finds the winning class (argmax) serially, one comparison per cycle. It presents the class index and score to downstream logic through a valid/ready handshake.

## Interface
- `N_OUT`, 10: number of class scores; index width is 4 bits.
- `W`, 16: score width; unsigned, non-negative after ReLU.
- `SLOTS`, 26: slots per schedule line. Slot counter range is 0..SLOTS-1.
- `LINES`, 30: lines per frame. Line counter range is 1..LINES.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_score_1` .. `in_score_10`  in  W each  class scores, driven directly by the layer's output registers.
- `res_ready`  in  1  downstream accepts the result.
- `res_valid`  out  1  result pending.
- `res_class`  out  4  winning index, 0..N_OUT-1.
- `res_max`  out  W  winning score.
- `overrun`  out  1  sticky flag: a pending result was overwritten.

## Operation
- **Schedule tracker.** Mirrors the layer's counters exactly.
  - Reset values: `cnt` = SLOTS-1, `line` = LINES.
  - Each non-reset edge: `cnt`++. When `cnt` would exceed SLOTS-1, `cnt` goes to 0 and `line`++, and `line` wraps from LINES to 1.
  - The layer rewrites score k (0-based) on the edge where `line`==1 and `cnt`==k.
- **Capture point.** The edge where `line`==1 and `cnt`==N_OUT. At this point all ten scores have been stable for at least one cycle.
- **States:** IDLE, SCAN, HOLD.
- **IDLE:** at the capture point:
  - load all ten inputs into the snapshot registers;
  - set `best_val` = snapshot[0], `best_idx` = 0, `idx` = 1;
  - go to SCAN.
- **SCAN:** each edge compares snapshot[`idx`] with `best_val`.
  - A strictly greater score replaces `best_val` and `best_idx`, so ties resolve to the lowest index.
  - `idx`++. The edge that compares `idx`==N_OUT-1 loads `res_class`/`res_max`, sets `res_valid`, and goes to HOLD.
- **HOLD:** outputs are held stable. An edge with `res_valid`&&`res_ready` clears `res_valid` and returns to IDLE.
- **Capture point in HOLD without acceptance:** behaviour depends on the macro; see Configuration.
- **Capture point on the same edge as acceptance:** the acceptance completes, the capture proceeds normally (state goes to SCAN), and `overrun` is not set.
- **Capture point in SCAN:** cannot occur, since the frame period (780) is far greater than N_OUT.
- **Arithmetic:** unsigned W-bit compare only; no widening.

## Timing
- **Reset values:** `res_valid`=0, `res_class`=0, `res_max`=0, `overrun`=0, state IDLE, tracker at (SLOTS-1, LINES). Reset takes effect immediately and asynchronously, mid-SCAN or mid-HOLD included.
- **Edge numbering:** edge 1 is the first rising edge with `rst` low.
  - Tracker reaches (`cnt` 0, `line` 1) at edge 1.
  - Scores are rewritten at edges 2..11.
  - Capture happens at edge 12.
- **Latency:** `res_valid` rises after edge 21, i.e. N_OUT-1 = 9 edges after capture.
- **Frame period:** SLOTS×LINES = 780 cycles. With `res_ready` tied high, successive `res_valid` rises are 780 cycles apart.
- **Handshake:** `res_valid` never drops without acceptance, except on reset or overwrite. `res_class`/`res_max` do not change while `res_valid` is high unless an overwrite occurs.

## Configuration
- Macro: `FC_READER_OVERWRITE_EN`.
- **Defined:** a capture point in HOLD without acceptance proceeds.
  - `res_valid` drops, state goes to SCAN, `overrun` is set.
  - `overrun` is sticky until `rst`.
- **Undefined:** that capture point is ignored. The pending result stays valid and unchanged, and `overrun` is constant 0.

## Test plan
- **Basic argmax:** scores 10,20,…,100 constant, `res_ready`=1, release reset → `res_valid` high after edge 21 for exactly one cycle, `res_class`=9, `res_max`=100.
- **Tie:** all scores 0x0050 → `res_class`=0, `res_max`=0x0050. Scores with a maximum of 0x0400 at indices 3 and 7 → `res_class`=3.
- **Backpressure:** `res_ready`=0; frame 1 has the maximum at index 2, frame 2 has the maximum at index 5.
  - Macro undefined: after edge 792 the outputs still show class 2, `overrun`=0.
  - Macro defined: after edge 801 the outputs show class 5, `overrun`=1.
- **Simultaneous accept and capture:** hold `res_valid` until edge 792 and pulse `res_ready` on that edge → `res_valid` drops, rises again after edge 801, `overrun`=0.
- **Reset mid-operation:** assert `rst` during SCAN (edge 15) → all outputs 0 at once. After re-release, `res_valid` rises after edge 21 counted from the new release.
- **Period:** `res_ready`=1 for 3 frames → `res_valid` pulses after edges 21, 801, 1581.

Source files
------------

// File: rtl/fc_result_reader.sv
// fc_result_reader
// Consumer at the output of the second fully connected layer. Mirrors the
// layer's free-running 26-slot x 30-line schedule, snapshots the ten class
// scores once per frame, finds the argmax serially (one compare per cycle)
// and offers {class, score} downstream through a valid/ready handshake.
//
// Ports:
//   clk                        system clock, rising edge
//   rst                        asynchronous active-high reset
//   in_score_1..in_score_10    W-bit unsigned class scores from the layer
//   res_ready                  downstream accepts the result
//   res_valid                  result pending
//   res_class                  winning class index, 0..N_OUT-1
//   res_max                    winning score
//   overrun                    sticky: a pending result was overwritten
//
// Build option: FC_READER_OVERWRITE_EN
//   defined   - a new frame arriving while a result is unaccepted replaces
//               it and sets overrun.
//   undefined - such a frame is dropped; overrun stays 0.

module fc_result_reader #(
   localparam int unsigned N_OUT  = 10,
   localparam int unsigned W      = 16,
   localparam int unsigned IDX_W  = 4,
   localparam int unsigned SLOTS  = 26,
   localparam int unsigned LINES  = 30,
   localparam int unsigned CNT_W  = $clog2(SLOTS),
   localparam int unsigned LINE_W = $clog2(LINES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     in_score_1,
   input  logic [W-1:0]     in_score_2,
   input  logic [W-1:0]     in_score_3,
   input  logic [W-1:0]     in_score_4,
   input  logic [W-1:0]     in_score_5,
   input  logic [W-1:0]     in_score_6,
   input  logic [W-1:0]     in_score_7,
   input  logic [W-1:0]     in_score_8,
   input  logic [W-1:0]     in_score_9,
   input  logic [W-1:0]     in_score_10,
   input  logic             res_ready,
   output logic             res_valid,
   output logic [IDX_W-1:0] res_class,
   output logic [W-1:0]     res_max,
   output logic             overrun
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [W-1:0]        snap_q [N_OUT];
   logic [W-1:0]        snap_d [N_OUT];
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [W-1:0]        best_val_q, best_val_d;
   logic [IDX_W-1:0]    best_idx_q, best_idx_d;
   logic                res_valid_q, res_valid_d;
   logic [IDX_W-1:0]    res_class_q, res_class_d;
   logic [W-1:0]        res_max_q, res_max_d;
   logic                overrun_q, overrun_d;

   logic                cap_c;
   logic                accept_c;
   logic                load_c;
   logic [W-1:0]        cur_c;

   // All ten scores are stable on the edge where the tracker sits at (N_OUT, 1).
   assign cap_c    = (line_q == LINE_W'(1)) && (cnt_q == CNT_W'(N_OUT));
   assign accept_c = res_valid_q && res_ready;
   assign cur_c    = snap_q[idx_q];

   // Next-state: schedule tracker, argmax FSM, result/overrun registers.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      snap_d      = snap_q;
      idx_d       = idx_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      res_valid_d = res_valid_q;
      res_class_d = res_class_q;
      res_max_d   = res_max_q;
      overrun_d   = overrun_q;
      load_c      = 1'b0;

      if (cnt_q == CNT_W'(SLOTS - 1)) begin
         cnt_d  = '0;
         line_d = (line_q == LINE_W'(LINES)) ? LINE_W'(1) : line_q + LINE_W'(1);
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (cap_c) load_c = 1'b1;
         end
         SCAN: begin
            // Strictly greater only: ties keep the lowest index.
            if (cur_c > best_val_q) begin
               best_val_d = cur_c;
               best_idx_d = idx_q;
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(N_OUT - 1)) begin
               res_valid_d = 1'b1;
               res_class_d = best_idx_d;
               res_max_d   = best_val_d;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (accept_c) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
            if (cap_c) begin
               if (accept_c) begin
                  load_c = 1'b1;
               end
`ifdef FC_READER_OVERWRITE_EN
               else begin
                  load_c      = 1'b1;
                  res_valid_d = 1'b0;
                  overrun_d   = 1'b1;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame capture: snapshot and seed the scan with entry 0.
      if (load_c) begin
         snap_d[0]  = in_score_1;
         snap_d[1]  = in_score_2;
         snap_d[2]  = in_score_3;
         snap_d[3]  = in_score_4;
         snap_d[4]  = in_score_5;
         snap_d[5]  = in_score_6;
         snap_d[6]  = in_score_7;
         snap_d[7]  = in_score_8;
         snap_d[8]  = in_score_9;
         snap_d[9]  = in_score_10;
         best_val_d = in_score_1;
         best_idx_d = '0;
         idx_d      = IDX_W'(1);
         state_d    = SCAN;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= CNT_W'(SLOTS - 1);
         line_q      <= LINE_W'(LINES);
         for (int i = 0; i < N_OUT; i++) snap_q[i] <= '0;
         idx_q       <= '0;
         best_val_q  <= '0;
         best_idx_q  <= '0;
         res_valid_q <= 1'b0;
         res_class_q <= '0;
         res_max_q   <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         line_q      <= line_d;
         for (int i = 0; i < N_OUT; i++) snap_q[i] <= snap_d[i];
         idx_q       <= idx_d;
         best_val_q  <= best_val_d;
         best_idx_q  <= best_idx_d;
         res_valid_q <= res_valid_d;
         res_class_q <= res_class_d;
         res_max_q   <= res_max_d;
         overrun_q   <= overrun_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_class = res_class_q;
   assign res_max   = res_max_q;
   assign overrun   = overrun_q;

endmodule
